// File: rtl/zx_pager_pkg.sv
// Shared constants and types for the zx_pager memory paging controller:
// port decode, fixed bank numbers, special-map bank sets and write FSM states.
package zx_pager_pkg;

  // Loose #7FFD decode used by the plain 128K machine: A15=0, A1=0.
  localparam logic [15:0] PORT_7FFD_MASK    = 16'h8002;
  localparam logic [15:0] PORT_7FFD_VAL     = 16'h0000;
  // Tightened #7FFD decode when #1FFD is present: A15:14=01, A1=0.
  localparam logic [15:0] PORT_7FFD_MASK_P3 = 16'hC002;
  localparam logic [15:0] PORT_7FFD_VAL_P3  = 16'h4000;
  localparam logic [15:0] PORT_1FFD_MASK    = 16'hF002;
  localparam logic [15:0] PORT_1FFD_VAL     = 16'h1000;

  // Banks permanently mapped at #4000 and #8000 in the normal map.
  localparam logic [2:0] BANK_SCREEN = 3'd5;
  localparam logic [2:0] BANK_MID    = 3'd2;

  // Special (all-RAM) map: first index is r1ffd[2:1], second is a[15:14].
  localparam logic [2:0] SPECIAL_MAP [0:3][0:3] = '{
    '{3'd0, 3'd1, 3'd2, 3'd3},
    '{3'd4, 3'd5, 3'd6, 3'd7},
    '{3'd4, 3'd5, 3'd6, 3'd3},
    '{3'd4, 3'd7, 3'd6, 3'd3}
  };

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_SEEN = 2'd1,
    WR_HOLD = 2'd2
  } wr_state_e;

endpackage

// File: rtl/zx_io_wr_sync.sv
// Glitch-filtered I/O write detector: a write must be seen on two consecutive
// edges to commit, and only one commit is issued per I/O cycle.
module zx_io_wr_sync
  import zx_pager_pkg::*;
(
  input  logic clkcpu,
  input  logic rst_n,
  input  logic wc,
  input  logic n_iorq,
  output logic commit
);

  wr_state_e state, state_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) state <= WR_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    unique case (state)
      WR_IDLE: if (wc) state_nxt = WR_SEEN;
      WR_SEEN: begin
        if (wc) begin
          state_nxt = WR_HOLD;
          commit    = 1'b1;
        end else begin
          state_nxt = WR_IDLE;
        end
      end
      WR_HOLD: if (n_iorq) state_nxt = WR_IDLE;
      default: state_nxt = WR_IDLE;
    endcase
  end

endmodule

// File: rtl/zx_pager.sv
// Parametrised ZX Spectrum paging controller: #7FFD / optional #1FFD registers,
// lock handling and combinational bank/ROM/chip-select mapping.
module zx_pager
  import zx_pager_pkg::*;
#(
  parameter int BANK_W  = 3,
  parameter int ROM_W   = 1,
  parameter int EN_1FFD = 0
) (
  input  logic              clkcpu,
  input  logic              rst_n,
  input  logic [15:0]       a,
  input  logic [7:0]        d,
  input  logic              n_iorq,
  input  logic              n_mreq,
  input  logic              n_wr,
  input  logic              n_rd,
  input  logic              n_m1,
  output logic [BANK_W-1:0] ram_bank,
  output logic              ram_cs_n,
  output logic              rom_cs_n,
  output logic [ROM_W-1:0]  rom_page,
  output logic              vbank,
  output logic              locked,
  output logic              page_upd
);

  logic [7:0] r7ffd;
  logic [7:0] r1ffd;
  logic       wc;
  logic       commit;
  logic       hit_7ffd;
  logic       hit_1ffd;
  logic       wr_ok;
  logic       special;
  logic       rom_map;
  logic [5:0] top_full;
  logic [1:0] rom_full;
  logic       rd_unused;

  // Reads never change paging state.
  assign rd_unused = n_rd;

  assign wc = ~n_iorq & ~n_wr & n_m1;

  zx_io_wr_sync u_wr_sync (
    .clkcpu (clkcpu),
    .rst_n  (rst_n),
    .wc     (wc),
    .n_iorq (n_iorq),
    .commit (commit)
  );

  assign hit_7ffd = (EN_1FFD != 0) ? ((a & PORT_7FFD_MASK_P3) == PORT_7FFD_VAL_P3)
                                   : ((a & PORT_7FFD_MASK)    == PORT_7FFD_VAL);
  assign hit_1ffd = (EN_1FFD != 0) && ((a & PORT_1FFD_MASK) == PORT_1FFD_VAL);

  // On 1024K builds bit 5 is a bank bit, so the lock does not exist there.
  assign locked = (BANK_W < 6) ? r7ffd[5] : 1'b0;
  assign wr_ok  = commit & ~locked;

  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      r7ffd    <= 8'h00;
      r1ffd    <= 8'h00;
      page_upd <= 1'b0;
    end else begin
      if (wr_ok && hit_7ffd) r7ffd <= d;
      if (wr_ok && hit_1ffd) r1ffd <= d;
      page_upd <= wr_ok && (hit_7ffd || hit_1ffd);
    end
  end

  assign top_full = {r7ffd[5], r7ffd[7], r7ffd[6], r7ffd[2:0]};
  assign rom_full = {(EN_1FFD != 0) && r1ffd[2], r7ffd[4]};
  assign rom_page = rom_full[ROM_W-1:0];
  assign vbank    = r7ffd[3];
  assign special  = (EN_1FFD != 0) && r1ffd[0];

  always_comb begin
    rom_map  = 1'b0;
    ram_bank = '0;
    if (special) begin
      ram_bank = BANK_W'(SPECIAL_MAP[r1ffd[2:1]][a[15:14]]);
    end else begin
      unique case (a[15:14])
        2'b00: rom_map  = 1'b1;
        2'b01: ram_bank = BANK_W'(BANK_SCREEN);
        2'b10: ram_bank = BANK_W'(BANK_MID);
        2'b11: ram_bank = top_full[BANK_W-1:0];
        default: ram_bank = '0;
      endcase
    end
  end

  assign rom_cs_n = ~(~n_mreq &  rom_map);
  assign ram_cs_n = ~(~n_mreq & ~rom_map);

endmodule

// File: tb/tb_zx_pager.sv
// Directed bench for zx_pager: four configurations share one CPU bus so each
// write sequence is checked against 128K, 512K, 1024K and +3-style builds.
module tb_zx_pager;

  logic        clkcpu = 1'b0;
  logic        rst_n  = 1'b0;
  logic [15:0] a      = 16'h0000;
  logic [7:0]  d      = 8'h00;
  logic        n_iorq = 1'b1;
  logic        n_mreq = 1'b1;
  logic        n_wr   = 1'b1;
  logic        n_rd   = 1'b1;
  logic        n_m1   = 1'b1;

  logic [2:0] b3_bank;  logic b3_ram_cs_n, b3_rom_cs_n, b3_vbank, b3_locked, b3_upd;
  logic [0:0] b3_rom;
  logic [4:0] b5_bank;  logic b5_ram_cs_n, b5_rom_cs_n, b5_vbank, b5_locked, b5_upd;
  logic [0:0] b5_rom;
  logic [5:0] b6_bank;  logic b6_ram_cs_n, b6_rom_cs_n, b6_vbank, b6_locked, b6_upd;
  logic [0:0] b6_rom;
  logic [2:0] p3_bank;  logic p3_ram_cs_n, p3_rom_cs_n, p3_vbank, p3_locked, p3_upd;
  logic [1:0] p3_rom;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] u1, u2, u3;

  always #5 clkcpu = ~clkcpu;

  zx_pager #(.BANK_W(3), .ROM_W(1), .EN_1FFD(0)) u_b3 (
    .clkcpu(clkcpu), .rst_n(rst_n), .a(a), .d(d), .n_iorq(n_iorq), .n_mreq(n_mreq),
    .n_wr(n_wr), .n_rd(n_rd), .n_m1(n_m1), .ram_bank(b3_bank), .ram_cs_n(b3_ram_cs_n),
    .rom_cs_n(b3_rom_cs_n), .rom_page(b3_rom), .vbank(b3_vbank), .locked(b3_locked),
    .page_upd(b3_upd));

  zx_pager #(.BANK_W(5), .ROM_W(1), .EN_1FFD(0)) u_b5 (
    .clkcpu(clkcpu), .rst_n(rst_n), .a(a), .d(d), .n_iorq(n_iorq), .n_mreq(n_mreq),
    .n_wr(n_wr), .n_rd(n_rd), .n_m1(n_m1), .ram_bank(b5_bank), .ram_cs_n(b5_ram_cs_n),
    .rom_cs_n(b5_rom_cs_n), .rom_page(b5_rom), .vbank(b5_vbank), .locked(b5_locked),
    .page_upd(b5_upd));

  zx_pager #(.BANK_W(6), .ROM_W(1), .EN_1FFD(0)) u_b6 (
    .clkcpu(clkcpu), .rst_n(rst_n), .a(a), .d(d), .n_iorq(n_iorq), .n_mreq(n_mreq),
    .n_wr(n_wr), .n_rd(n_rd), .n_m1(n_m1), .ram_bank(b6_bank), .ram_cs_n(b6_ram_cs_n),
    .rom_cs_n(b6_rom_cs_n), .rom_page(b6_rom), .vbank(b6_vbank), .locked(b6_locked),
    .page_upd(b6_upd));

  zx_pager #(.BANK_W(3), .ROM_W(2), .EN_1FFD(1)) u_p3 (
    .clkcpu(clkcpu), .rst_n(rst_n), .a(a), .d(d), .n_iorq(n_iorq), .n_mreq(n_mreq),
    .n_wr(n_wr), .n_rd(n_rd), .n_m1(n_m1), .ram_bank(p3_bank), .ram_cs_n(p3_ram_cs_n),
    .rom_cs_n(p3_rom_cs_n), .rom_page(p3_rom), .vbank(p3_vbank), .locked(p3_locked),
    .page_upd(p3_upd));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Asynchronous reset asserted mid-cycle, held over one edge, released at negedge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    n_iorq = 1'b1; n_wr = 1'b1; n_mreq = 1'b1; n_m1 = 1'b1;
    @(negedge clkcpu);
    rst_n = 1'b1;
  endtask

  // One OUT cycle: u1/u2/u3 hold {b3,b5,b6,p3} page_upd after edges 1, 2, 3.
  task automatic io_write(input logic [15:0] addr, input logic [7:0] data,
                          output logic [3:0] o1, output logic [3:0] o2, output logic [3:0] o3);
    @(negedge clkcpu);
    n_mreq = 1'b1; a = addr; d = data; n_iorq = 1'b0; n_wr = 1'b0; n_m1 = 1'b1;
    @(negedge clkcpu);
    o1 = {b3_upd, b5_upd, b6_upd, p3_upd};
    @(negedge clkcpu);
    o2 = {b3_upd, b5_upd, b6_upd, p3_upd};
    n_iorq = 1'b1; n_wr = 1'b1;
    @(negedge clkcpu);
    o3 = {b3_upd, b5_upd, b6_upd, p3_upd};
  endtask

  task automatic mem_rd(input logic [15:0] addr);
    @(negedge clkcpu);
    a = addr; n_mreq = 1'b0;
    #2;
  endtask

  initial begin
    // Reset state, sampled while rst_n is low and n_mreq high.
    #3;
    check("rst_locked_b3", b3_locked, 1'b0);
    check("rst_upd_b3", b3_upd, 1'b0);
    check("rst_rom_cs_b3", b3_rom_cs_n, 1'b1);
    check("rst_ram_cs_b3", b3_ram_cs_n, 1'b1);
    check("rst_vbank_b3", b3_vbank, 1'b0);
    check("rst_rom_p3", p3_rom, 2'd0);
    @(negedge clkcpu);
    rst_n = 1'b1;

    mem_rd(16'h0000);
    check("rd0_rom_cs_b3", b3_rom_cs_n, 1'b0);
    check("rd0_ram_cs_b3", b3_ram_cs_n, 1'b1);
    check("rd0_rom_page_b3", b3_rom, 1'b0);
    check("rd0_rom_cs_p3", p3_rom_cs_n, 1'b0);

    // Basic 128K write: #13 -> bank 3, ROM 1.
    io_write(16'h7FFD, 8'h13, u1, u2, u3);
    check("w13_upd_e1", u1, 4'b0000);
    check("w13_upd_e2", u2, 4'b1111);
    check("w13_upd_e3", u3, 4'b0000);
    mem_rd(16'hC000);
    check("w13_bank_b3", b3_bank, 3'd3);
    check("w13_rom_b3", b3_rom, 1'b1);
    check("w13_ram_cs_b3", b3_ram_cs_n, 1'b0);
    check("w13_rom_cs_b3", b3_rom_cs_n, 1'b1);
    check("w13_bank_b5", b5_bank, 5'd3);
    check("w13_vbank_b3", b3_vbank, 1'b0);
    io_write(16'h7FFD, 8'h18, u1, u2, u3);
    mem_rd(16'hC000);
    check("w18_vbank_b3", b3_vbank, 1'b1);
    check("w18_bank_b3", b3_bank, 3'd0);

    // Lock sequence.
    do_reset();
    io_write(16'h7FFD, 8'h20, u1, u2, u3);
    check("lock_set_upd", u2, 4'b1111);
    check("lock_b3", b3_locked, 1'b1);
    check("lock_b5", b5_locked, 1'b1);
    check("lock_b6", b6_locked, 1'b0);
    mem_rd(16'hC000);
    check("lock_bank_b6", b6_bank, 6'd32);
    io_write(16'h7FFD, 8'h07, u1, u2, u3);
    check("locked_wr_upd", u2, 4'b0010);
    mem_rd(16'hC000);
    check("locked_bank_b3", b3_bank, 3'd0);
    check("locked_bank_b5", b5_bank, 5'd0);
    check("unlocked_bank_b6", b6_bank, 6'd7);
    check("unlocked_b6_still", b6_locked, 1'b0);

    // Extended bank bits.
    do_reset();
    io_write(16'h7FFD, 8'hC7, u1, u2, u3);
    mem_rd(16'hC000);
    check("ext_bank_b5", b5_bank, 5'd31);
    check("ext_bank_b6", b6_bank, 6'd31);
    check("ext_bank_b3", b3_bank, 3'd7);
    mem_rd(16'h4000);
    check("fix5_b5", b5_bank, 5'd5);
    mem_rd(16'h8000);
    check("fix2_b5", b5_bank, 5'd2);
    check("fix2_ram_cs_b5", b5_ram_cs_n, 1'b0);

    // #1FFD special paging.
    do_reset();
    io_write(16'h1FFD, 8'h07, u1, u2, u3);
    check("p3_1ffd_upd", u2, 4'b1111);
    mem_rd(16'h0000);
    check("sp_bank0_p3", p3_bank, 3'd4);
    check("sp_rom_cs_p3", p3_rom_cs_n, 1'b1);
    check("sp_ram_cs_p3", p3_ram_cs_n, 1'b0);
    mem_rd(16'h4000);
    check("sp_bank1_p3", p3_bank, 3'd7);
    mem_rd(16'hC000);
    check("sp_bank3_p3", p3_bank, 3'd3);
    check("alias_1ffd_b3", b3_bank, 3'd7);
    io_write(16'h1FFD, 8'h04, u1, u2, u3);
    mem_rd(16'h0000);
    check("rom2_p3", p3_rom, 2'd2);
    check("rom2_cs_p3", p3_rom_cs_n, 1'b0);
    mem_rd(16'hC000);
    check("tight_decode_p3", p3_bank, 3'd0);
    // Loose-decode address must not reach #7FFD on the +3 build.
    io_write(16'h3FFD, 8'h01, u1, u2, u3);
    check("tight_upd_p3", u2, 4'b1110);

    // Single-cycle write glitch.
    do_reset();
    @(negedge clkcpu);
    n_mreq = 1'b1; a = 16'h7FFD; d = 8'h07; n_iorq = 1'b0; n_wr = 1'b0;
    @(negedge clkcpu);
    n_iorq = 1'b1; n_wr = 1'b1;
    @(negedge clkcpu);
    check("glitch_upd_e2", {b3_upd, b5_upd, b6_upd, p3_upd}, 4'b0000);
    @(negedge clkcpu);
    check("glitch_upd_e3", {b3_upd, b5_upd, b6_upd, p3_upd}, 4'b0000);
    mem_rd(16'hC000);
    check("glitch_bank_b3", b3_bank, 3'd0);

    // Reset while the FSM sits in SEEN.
    io_write(16'h7FFD, 8'h03, u1, u2, u3);
    @(negedge clkcpu);
    n_mreq = 1'b1; a = 16'h7FFD; d = 8'h05; n_iorq = 1'b0; n_wr = 1'b0;
    @(negedge clkcpu);
    rst_n = 1'b0;
    #1;
    check("rst_seen_upd", b3_upd, 1'b0);
    n_iorq = 1'b1; n_wr = 1'b1;
    @(negedge clkcpu);
    rst_n = 1'b1;
    mem_rd(16'hC000);
    check("rst_seen_bank_b3", b3_bank, 3'd0);
    check("rst_seen_vbank_b3", b3_vbank, 1'b0);
    io_write(16'h7FFD, 8'h06, u1, u2, u3);
    check("post_rst_upd_e1", u1, 4'b0000);
    check("post_rst_upd_e2", u2, 4'b1111);
    mem_rd(16'hC000);
    check("post_rst_bank_b3", b3_bank, 3'd6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
